// File: rtl/alu_pkg.sv
// Shared constants for the ALU front-end: opcode map, sequencer state encoding
// and the default datapath width.
package alu_pkg;

    localparam int ALU_WIDTH = 4;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_NOT = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_LT  = 3'd6;
    localparam logic [2:0] OP_EQ  = 3'd7;

    localparam logic [2:0] OP_SEL_MIN = OP_ADD;
    localparam logic [2:0] OP_SEL_MAX = OP_EQ;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer plus stability counter for one raw push button;
// emits a one-cycle press pulse on the accepted 0->1 transition only.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic        sync_p0;
    logic        sync_p1;
    logic [15:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
            press   <= 1'b0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            press   <= 1'b0;
            // Any sample agreeing with the accepted level restarts the run of differing samples.
            if (sync_p1 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync_p1;
                press <= sync_p1;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Board front-end for the combinational ALU: debounced saturating opcode
// selection plus a three-state latch/settle/capture sequencer.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int WIDTH           = ALU_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    btn_up,
    input  logic                    btn_down,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic [2:0]              op_led,
    output logic                    busy,
    output logic                    done,
    output logic signed [WIDTH-1:0] result,
    output logic                    carry,
    output logic                    zero,
    output logic                    overflow,
    output logic [2:0]              alu_ctrl,
    output logic signed [WIDTH-1:0] alu_a,
    output logic signed [WIDTH-1:0] alu_b,
    input  logic signed [WIDTH-1:0] alu_result,
    input  logic                    alu_carry,
    input  logic                    alu_zero,
    input  logic                    alu_overflow
);

    logic       up_press;
    logic       down_press;
    logic       up_level_unused;
    logic       down_level_unused;
    logic [2:0] op_sel;
    logic [1:0] state;

    // Simultaneous up/down cancel; the ends of the range hold rather than wrap.
    function automatic logic [2:0] sat_step(input logic [2:0] cur,
                                            input logic       up,
                                            input logic       down);
        logic [2:0] nxt;
        nxt = cur;
        if (up && !down && cur != OP_SEL_MAX) nxt = cur + 3'd1;
        if (down && !up && cur != OP_SEL_MIN) nxt = cur - 3'd1;
        return nxt;
    endfunction

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up_db (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_up),
        .level (up_level_unused),
        .press (up_press)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down_db (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_down),
        .level (down_level_unused),
        .press (down_press)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) op_sel <= '0;
        else     op_sel <= sat_step(op_sel, up_press, down_press);
    end

    assign op_led = op_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_ctrl <= '0;
            result   <= '0;
            carry    <= 1'b0;
            zero     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        alu_a    <= a;
                        alu_b    <= b;
                        alu_ctrl <= op_sel;
                        busy     <= 1'b1;
                        state    <= EXEC;
                    end
                end
                // ALU inputs have had a full cycle to settle; capture its outputs.
                EXEC: begin
                    result   <= alu_result;
                    carry    <= alu_carry;
                    zero     <= alu_zero;
                    overflow <= alu_overflow;
                    done     <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
